pipeline_ctrl: RTL

Stage sequencer for the 5-stage MIPS pipelined datapath. Drives each stage's rst/en pair (IF, ID, EXE, MEM, WB) from per-stage hazard feedback, branch indications and a data-memory ready handshake. Sequences boot, RAW-hazard stalls, branch flushes, memory wait states and a fatal-timeout halt. Provides saturating stall and flush counters for debug.

---
 rtl/pipeline_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stage sequencer for a 5-stage MIPS pipeline.
//
// Drives the rst/en pair of each stage (IF, ID, EXE, MEM, WB). It holds all
// stages in reset during boot, stalls IF/ID on RAW hazards, flushes wrong-path
// instructions on a taken branch, and freezes the front of the pipe while data
// memory is busy. If memory never answers, it halts for debug. Saturating
// stall/flush counters are exported for debug.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rs_used_id_i, rt_used_id_i  ID instruction reads rs / rt
//   addr_rs_id_i, addr_rt_id_i  ID source register addresses
//   regw_addr_{exe,mem,wb}_i    destination register per stage
//   wb_wen_{exe,mem,wb}_i       stage instruction writes a register
//   is_branch_mem_i             MEM instruction redirects the PC
//   mem_req_i, mem_ack_i        data memory request / completion
//   {if,id,exe,mem,wb}_rst_o    synchronous stage resets to the datapath
//   {if,id,exe,mem,wb}_en_o     stage enables to the datapath
//   halted_o                    memory timeout occurred (cleared by rst_n only)
//   stall_cnt_o, flush_cnt_o    saturating debug counters
module pipeline_ctrl #(
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned WB_BYPASS   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rs_used_id_i,
    input  logic        rt_used_id_i,
    input  logic [4:0]  addr_rs_id_i,
    input  logic [4:0]  addr_rt_id_i,
    input  logic [4:0]  regw_addr_exe_i,
    input  logic        wb_wen_exe_i,
    input  logic [4:0]  regw_addr_mem_i,
    input  logic        wb_wen_mem_i,
    input  logic [4:0]  regw_addr_wb_i,
    input  logic        wb_wen_wb_i,
    input  logic        is_branch_mem_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        if_rst_o,
    output logic        id_rst_o,
    output logic        exe_rst_o,
    output logic        mem_rst_o,
    output logic        wb_rst_o,
    output logic        if_en_o,
    output logic        id_en_o,
    output logic        exe_en_o,
    output logic        mem_en_o,
    output logic        wb_en_o,
    output logic        halted_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    typedef enum logic [1:0] {StBoot, StRun, StMemWait, StHalt} state_e;

    state_e      state_q, state_d;
    logic [3:0]  boot_q, boot_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    logic hazard;
    logic mem_wait;

    // True when a source register is pending in a later stage. r0 is hardwired
    // to zero and never depends on anything.
    function automatic logic src_hazard(input logic used, input logic [4:0] addr,
                                        input logic [4:0] a_exe, input logic w_exe,
                                        input logic [4:0] a_mem, input logic w_mem,
                                        input logic [4:0] a_wb, input logic w_wb);
        logic hit;
        hit = (w_exe && (addr == a_exe)) || (w_mem && (addr == a_mem));
        if (WB_BYPASS == 0) begin
            hit = hit || (w_wb && (addr == a_wb));
        end
        return used && (addr != 5'd0) && hit;
    endfunction

    always_comb begin
        hazard = src_hazard(rs_used_id_i, addr_rs_id_i,
                            regw_addr_exe_i, wb_wen_exe_i,
                            regw_addr_mem_i, wb_wen_mem_i,
                            regw_addr_wb_i, wb_wen_wb_i) ||
                 src_hazard(rt_used_id_i, addr_rt_id_i,
                            regw_addr_exe_i, wb_wen_exe_i,
                            regw_addr_mem_i, wb_wen_mem_i,
                            regw_addr_wb_i, wb_wen_wb_i);
        mem_wait = mem_req_i && !mem_ack_i;
    end

    always_comb begin
        state_d   = state_q;
        boot_d    = boot_q;
        wait_d    = wait_q;
        stall_d   = stall_q;
        flush_d   = flush_q;
        if_rst_o  = 1'b0;
        id_rst_o  = 1'b0;
        exe_rst_o = 1'b0;
        mem_rst_o = 1'b0;
        wb_rst_o  = 1'b0;
        if_en_o   = 1'b0;
        id_en_o   = 1'b0;
        exe_en_o  = 1'b0;
        mem_en_o  = 1'b0;
        wb_en_o   = 1'b0;

        unique case (state_q)
            StBoot: begin
                if_rst_o  = 1'b1;
                id_rst_o  = 1'b1;
                exe_rst_o = 1'b1;
                mem_rst_o = 1'b1;
                wb_rst_o  = 1'b1;
                if (boot_q >= 4'(BOOT_CYCLES - 1)) begin
                    state_d = StRun;
                    boot_d  = 4'd0;
                end else begin
                    boot_d = boot_q + 4'd1;
                end
            end

            StRun, StMemWait: begin
                state_d = StRun;
                if (mem_wait) begin
                    // Freeze IF..MEM and push a bubble into WB so the stalled
                    // MEM instruction does not retire twice.
                    wb_rst_o = 1'b1;
                    wb_en_o  = 1'b1;
                    // The first wait cycle is counted in RUN, so entry restarts at 1.
                    wait_d   = (state_q == StRun) ? 16'd1 : wait_q + 16'd1;
                    state_d  = (wait_d >= 16'(MEM_TIMEOUT)) ? StHalt : StMemWait;
                    if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
                end else if (is_branch_mem_i) begin
                    // Kill the two wrong-path instructions and bubble MEM.
                    if_en_o   = 1'b1;
                    id_en_o   = 1'b1;
                    exe_en_o  = 1'b1;
                    mem_en_o  = 1'b1;
                    wb_en_o   = 1'b1;
                    id_rst_o  = 1'b1;
                    exe_rst_o = 1'b1;
                    mem_rst_o = 1'b1;
                    if (flush_q != 16'hFFFF) flush_d = flush_q + 16'd1;
                end else if (hazard) begin
                    // Hold IF/ID, insert a bubble in EXE, let older work drain.
                    exe_rst_o = 1'b1;
                    exe_en_o  = 1'b1;
                    mem_en_o  = 1'b1;
                    wb_en_o   = 1'b1;
                    if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
                end else begin
                    if_en_o  = 1'b1;
                    id_en_o  = 1'b1;
                    exe_en_o = 1'b1;
                    mem_en_o = 1'b1;
                    wb_en_o  = 1'b1;
                end
            end

            StHalt: begin
                // Everything frozen for debug; only rst_n leaves this state.
            end

            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
            boot_q  <= 4'd0;
            wait_q  <= 16'd0;
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign halted_o    = (state_q == StHalt);
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule
